// File: rtl/bmp_cmd_pkg.sv
// Shared types and defaults for the bitmap/font placement command master.
// A command is one queued draw request; the FSM turns it into bus writes.
package bmp_cmd_pkg;

  localparam int          DEPTH_DEF     = 4;
  localparam logic [15:0] ADDR_X_DEF    = 16'hC008;
  localparam logic [15:0] ADDR_Y_DEF    = 16'hC009;
  localparam logic [15:0] ADDR_CTRL_DEF = 16'hC00A;
  localparam int          GAP_DEF       = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_X,
    ST_WR_Y,
    ST_WR_C,
    ST_HOLD
  } state_t;

  typedef struct packed {
    logic [9:0] x;
    logic [8:0] y;
    logic [5:0] idx;
    logic       img;
  } cmd_t;

  function automatic logic [15:0] pack_x(input cmd_t c);
    return {6'b0, c.x};
  endfunction

  function automatic logic [15:0] pack_y(input cmd_t c);
    return {7'b0, c.y};
  endfunction

  function automatic logic [15:0] pack_ctrl(input cmd_t c);
    return {9'b0, c.idx, c.img};
  endfunction

endpackage

// File: rtl/bmp_cmd_fifo.sv
// Synchronous FIFO of draw commands. Occupancy comes from an explicit count
// register; pointers wrap naturally because DEPTH is a power of two.
module bmp_cmd_fifo
  import bmp_cmd_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  cmd_t                     i_data,
  input  logic                     i_pop,
  output cmd_t                     o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int             AW       = $clog2(DEPTH);
  localparam logic [AW:0]    FULL_CNT = (AW + 1)'(DEPTH);

  cmd_t          r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push_ok;
  logic          w_pop_ok;

  assign o_full    = (r_count == FULL_CNT);
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_data    = r_mem[r_rd_ptr];
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  // NOTE: the storage array has no reset; an entry is never read before it
  // is written, and leaving it out keeps it a plain RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/bmp_cmd_master.sv
// Bus initiator for the bitmap/font placement peripheral: queues draw requests
// and emits X / Y / CTRL register writes, skipping X/Y writes the display holds.
module bmp_cmd_master
  import bmp_cmd_pkg::*;
#(
  parameter int          DEPTH     = DEPTH_DEF,
  parameter logic [15:0] ADDR_X    = ADDR_X_DEF,
  parameter logic [15:0] ADDR_Y    = ADDR_Y_DEF,
  parameter logic [15:0] ADDR_CTRL = ADDR_CTRL_DEF,
  parameter int          GAP       = GAP_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_vld,
  output logic                   req_rdy,
  input  logic [9:0]             req_x,
  input  logic [8:0]             req_y,
  input  logic [5:0]             req_idx,
  input  logic                   req_img,
  input  logic                   plc_busy,
  output logic                   bmp_sel,
  output logic [15:0]            addr,
  output logic [15:0]            databus,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] fifo_cnt
);

  cmd_t        w_req;
  cmd_t        w_head;
  logic        w_full;
  logic        w_empty;
  logic        w_push;
  logic        w_hold_done;
  logic        w_launch;
  logic        w_y_needed;
  state_t      w_first;

  state_t      r_state;
  cmd_t        r_cmd;
  logic [9:0]  r_shadow_x;
  logic [8:0]  r_shadow_y;
  logic        r_shadow_vld;
  logic [15:0] r_gap_cnt;
  logic        r_bmp_sel;
  logic [15:0] r_addr;
  logic [15:0] r_databus;

  assign w_req  = '{x: req_x, y: req_y, idx: req_idx, img: req_img};
  assign w_push = req_vld && !w_full;

  bmp_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (w_req),
    .i_pop   (w_launch),
    .o_data  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (fifo_cnt)
  );

  // Leaving HOLD runs the IDLE dispatch in the same cycle, so a queued command
  // follows its predecessor after exactly GAP+1 quiet bus cycles.
  assign w_hold_done = (r_gap_cnt == '0) && !plc_busy;
  assign w_launch    = !w_empty &&
                       ((r_state == ST_IDLE) || ((r_state == ST_HOLD) && w_hold_done));
  assign w_y_needed  = !r_shadow_vld || (r_cmd.y != r_shadow_y);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    w_first = ST_WR_C;
    if (!r_shadow_vld || (w_head.x != r_shadow_x)) begin
      w_first = ST_WR_X;
    end else if (w_head.y != r_shadow_y) begin
      w_first = ST_WR_Y;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge value of every other register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_cmd        <= '0;
      r_shadow_x   <= '0;
      r_shadow_y   <= '0;
      r_shadow_vld <= 1'b0;
      r_gap_cnt    <= '0;
      r_bmp_sel    <= 1'b0;
      r_addr       <= '0;
      r_databus    <= '0;
    end else begin
      r_bmp_sel <= 1'b0;
      r_addr    <= '0;
      r_databus <= '0;
      if (w_launch) begin
        r_cmd   <= w_head;
        r_state <= w_first;
      end else begin
        case (r_state)
          ST_IDLE: r_state <= ST_IDLE;
          ST_WR_X: begin
            r_bmp_sel  <= 1'b1;
            r_addr     <= ADDR_X;
            r_databus  <= pack_x(r_cmd);
            r_shadow_x <= r_cmd.x;
            r_state    <= w_y_needed ? ST_WR_Y : ST_WR_C;
          end
          ST_WR_Y: begin
            r_bmp_sel  <= 1'b1;
            r_addr     <= ADDR_Y;
            r_databus  <= pack_y(r_cmd);
            r_shadow_y <= r_cmd.y;
            r_state    <= ST_WR_C;
          end
          ST_WR_C: begin
            r_bmp_sel    <= 1'b1;
            r_addr       <= ADDR_CTRL;
            r_databus    <= pack_ctrl(r_cmd);
            r_shadow_vld <= 1'b1;
            r_gap_cnt    <= 16'(GAP);
            r_state      <= ST_HOLD;
          end
          ST_HOLD: begin
            if (w_hold_done) begin
              r_state <= ST_IDLE;
            end else if (r_gap_cnt != '0) begin
              r_gap_cnt <= r_gap_cnt - 1'b1;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign req_rdy = !w_full;
  assign bmp_sel = r_bmp_sel;
  assign addr    = r_addr;
  assign databus = r_databus;
  assign busy    = (r_state != ST_IDLE) || !w_empty;

endmodule

// File: tb/tb_bmp_cmd_master.sv
// Scoreboard bench for bmp_cmd_master: a GAP=16 instance for the main tests
// and a GAP=0 instance for back-to-back command spacing.
module tb_bmp_cmd_master;

  localparam logic [15:0] AX = 16'hC008;
  localparam logic [15:0] AY = 16'hC009;
  localparam logic [15:0] AC = 16'hC00A;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] d;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic        req_vld = 1'b0, req_rdy, req_img = 1'b0, plc_busy = 1'b0;
  logic [9:0]  req_x = '0;
  logic [8:0]  req_y = '0;
  logic [5:0]  req_idx = '0;
  logic        bmp_sel, busy;
  logic [15:0] addr, databus;
  logic [2:0]  fifo_cnt;

  logic        q0_vld = 1'b0, q0_rdy, q0_img = 1'b0, q0_plc = 1'b0;
  logic [9:0]  q0_x = '0;
  logic [8:0]  q0_y = '0;
  logic [5:0]  q0_idx = '0;
  logic        b0_sel, b0_busy;
  logic [15:0] b0_addr, b0_data;
  logic [2:0]  b0_cnt;

  exp_t exp_q[$];
  exp_t exp0_q[$];
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bmp_cmd_master #(.DEPTH(4), .GAP(16)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy),
    .req_x(req_x), .req_y(req_y), .req_idx(req_idx), .req_img(req_img),
    .plc_busy(plc_busy), .bmp_sel(bmp_sel), .addr(addr), .databus(databus),
    .busy(busy), .fifo_cnt(fifo_cnt)
  );

  bmp_cmd_master #(.DEPTH(4), .GAP(0)) dut0 (
    .clk(clk), .rst(rst), .req_vld(q0_vld), .req_rdy(q0_rdy),
    .req_x(q0_x), .req_y(q0_y), .req_idx(q0_idx), .req_img(q0_img),
    .plc_busy(q0_plc), .bmp_sel(b0_sel), .addr(b0_addr), .databus(b0_data),
    .busy(b0_busy), .fifo_cnt(b0_cnt)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // mask bits: [2]=X write expected, [1]=Y write expected, [0]=CTRL write
  task automatic push_exp(input bit to0, input logic [9:0] x, input logic [8:0] y,
                          input logic [5:0] idx, input logic img, input logic [2:0] mask);
    exp_t e;
    if (mask[2]) begin
      e = '{a: AX, d: {6'b0, x}};
      if (to0) exp0_q.push_back(e); else exp_q.push_back(e);
    end
    if (mask[1]) begin
      e = '{a: AY, d: {7'b0, y}};
      if (to0) exp0_q.push_back(e); else exp_q.push_back(e);
    end
    if (mask[0]) begin
      e = '{a: AC, d: {9'b0, idx, img}};
      if (to0) exp0_q.push_back(e); else exp_q.push_back(e);
    end
  endtask

  task automatic send(input bit to0, input logic [9:0] x, input logic [8:0] y,
                      input logic [5:0] idx, input logic img, input logic [2:0] mask);
    int n;
    @(negedge clk);
    if (to0) begin
      q0_x = x; q0_y = y; q0_idx = idx; q0_img = img; q0_vld = 1'b1;
    end else begin
      req_x = x; req_y = y; req_idx = idx; req_img = img; req_vld = 1'b1;
    end
    n = 0;
    while (!(to0 ? q0_rdy : req_rdy) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("accept", 32'(n < 500), 32'd1);
    push_exp(to0, x, y, idx, img, mask);
    @(posedge clk);
    #1;
    if (to0) q0_vld = 1'b0; else req_vld = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || exp0_q.size() != 0 || busy || b0_busy) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n < 2000), 32'd1);
  endtask

  // Bus monitor, GAP=16 instance: data order plus inter-write spacing.
  initial begin : mon_main
    int   idle;
    bit   armed;
    bit   prev_ctrl;
    exp_t e;
    idle = 0; armed = 0; prev_ctrl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        idle = 0; armed = 0; prev_ctrl = 0;
      end else if (bmp_sel) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {addr, databus}, 32'd0);
          prev_ctrl = (addr == AC);
        end else begin
          e = exp_q.pop_front();
          check("bus_addr", 32'(addr), 32'(e.a));
          check("bus_data", 32'(databus), 32'(e.d));
          if (armed) begin
            if (prev_ctrl) check("cmd_gap_min17", 32'(idle >= 17), 32'd1);
            else           check("write_back_to_back", 32'(idle), 32'd0);
          end
          prev_ctrl = (e.a == AC);
        end
        armed = 1;
        idle  = 0;
      end else begin
        idle++;
      end
    end
  end

  // Bus monitor, GAP=0 instance: exactly one quiet cycle between commands.
  initial begin : mon_gap0
    int   idle;
    bit   armed;
    bit   prev_ctrl;
    exp_t e;
    idle = 0; armed = 0; prev_ctrl = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        idle = 0; armed = 0; prev_ctrl = 0;
      end else if (b0_sel) begin
        if (exp0_q.size() == 0) begin
          check("g0_unexpected_write", {b0_addr, b0_data}, 32'd0);
          prev_ctrl = (b0_addr == AC);
        end else begin
          e = exp0_q.pop_front();
          check("g0_bus_addr", 32'(b0_addr), 32'(e.a));
          check("g0_bus_data", 32'(b0_data), 32'(e.d));
          if (armed) begin
            if (prev_ctrl) check("g0_cmd_gap", 32'(idle), 32'd1);
            else           check("g0_back_to_back", 32'(idle), 32'd0);
          end
          prev_ctrl = (e.a == AC);
        end
        armed = 1;
        idle  = 0;
      end else begin
        idle++;
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n;
    #12;
    check("rst_bmp_sel",  32'(bmp_sel),  32'd0);
    check("rst_addr",     32'(addr),     32'd0);
    check("rst_databus",  32'(databus),  32'd0);
    check("rst_busy",     32'(busy),     32'd0);
    check("rst_fifo_cnt", 32'(fifo_cnt), 32'd0);
    check("rst_req_rdy",  32'(req_rdy),  32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: full X/Y/CTRL after reset, with first-write latency
    send(0, 10'd100, 9'd50, 6'd3, 1'b1, 3'b111);
    check("busy_after_push", 32'(busy), 32'd1);
    @(negedge clk); check("lat_cycle1", 32'(bmp_sel), 32'd0);
    @(negedge clk); check("lat_cycle2", 32'(bmp_sel), 32'd0);
    @(negedge clk); check("lat_cycle3", 32'(bmp_sel), 32'd1);
    drain("drain_t1");

    // 2: same X/Y, only CTRL written
    send(0, 10'd100, 9'd50, 6'd5, 1'b0, 3'b001);
    drain("drain_t2");

    // 3: new X, same Y
    send(0, 10'd200, 9'd50, 6'd2, 1'b1, 3'b101);
    drain("drain_t3");

    // 4: placement engine busy, FIFO fills, then drains in order
    @(negedge clk);
    plc_busy = 1'b1;
    send(0, 10'd10,  9'd20,  6'd1,  1'b1, 3'b111);
    send(0, 10'd10,  9'd20,  6'd2,  1'b0, 3'b001);
    send(0, 10'd11,  9'd20,  6'd3,  1'b0, 3'b101);
    send(0, 10'd11,  9'd21,  6'd4,  1'b1, 3'b011);
    send(0, 10'd300, 9'd400, 6'd63, 1'b1, 3'b111);
    @(negedge clk);
    req_x = 10'd0; req_y = 9'd0; req_idx = 6'd0; req_img = 1'b0; req_vld = 1'b1;
    check("full_fifo_cnt", 32'(fifo_cnt), 32'd4);
    check("full_req_rdy",  32'(req_rdy),  32'd0);
    repeat (20) @(negedge clk);
    check("stall_fifo_cnt", 32'(fifo_cnt), 32'd4);
    check("stall_req_rdy",  32'(req_rdy),  32'd0);
    check("stall_no_write", 32'(bmp_sel),  32'd0);
    push_exp(0, 10'd0, 9'd0, 6'd0, 1'b0, 3'b111);
    plc_busy = 1'b0;
    n = 0;
    while (!req_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("req6_accept_wait", 32'(n), 32'd1);
    @(posedge clk);
    #1;
    req_vld = 1'b0;
    check("refill_fifo_cnt", 32'(fifo_cnt), 32'd4);
    drain("drain_t4");

    // 5: reset while the Y write is on the bus
    send(0, 10'd123, 9'd45, 6'd9, 1'b1, 3'b111);
    n = 0;
    while (!(bmp_sel && addr == AY) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("saw_wr_y", 32'(n < 100), 32'd1);
    #1;
    rst = 1'b1;
    #1;
    check("async_bmp_sel",  32'(bmp_sel),  32'd0);
    check("async_addr",     32'(addr),     32'd0);
    check("async_databus",  32'(databus),  32'd0);
    check("async_fifo_cnt", 32'(fifo_cnt), 32'd0);
    check("async_busy",     32'(busy),     32'd0);
    check("aborted_ctrl_pending", 32'(exp_q.size()), 32'd1);
    exp_q.delete();
    @(negedge clk);
    #1;
    rst = 1'b0;
    send(0, 10'd123, 9'd45, 6'd9, 1'b1, 3'b111);
    drain("drain_t5");

    // 6: GAP=0 instance, two queued commands
    send(1, 10'd1, 9'd2, 6'd3, 1'b0, 3'b111);
    send(1, 10'd1, 9'd2, 6'd4, 1'b1, 3'b001);
    drain("drain_t6");

    check("scoreboard_empty", 32'(exp_q.size() + exp0_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
